regfile_wb_arbiter: RTL

Sequences the single write port of the 64-bit, 32-entry register file between the in-order pipeline writeback stage and a long-latency unit (mul/div). It keeps a scoreboard of destination registers owned by in-flight long-latency ops and issues hazard stalls to decode. It also forces pipeline bubbles when the long-latency unit has been starved of the write port.

---
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: pipeline WB, long-latency
// issue/retire handshakes, decode hazard query and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            pl_valid;
    logic [4:0]      pl_rd;
    logic [XLEN-1:0] pl_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            iss_ready;
    logic            lu_valid;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            lu_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_used;
    logic            hz_stall;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            waw_err;

    modport slave (
        input  pl_valid, pl_rd, pl_data,
        input  iss_valid, iss_rd,
        output iss_ready,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        input  rs1, rs2, rd, rs1_used, rs2_used, rd_used,
        output hz_stall,
        output rf_we, rf_waddr, rf_wdata,
        output waw_err
    );

    modport master (
        output pl_valid, pl_rd, pl_data,
        output iss_valid, iss_rd,
        input  iss_ready,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        output rs1, rs2, rd, rs1_used, rs2_used, rd_used,
        input  hz_stall,
        input  rf_we, rf_waddr, rf_wdata,
        input  waw_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by pipeline WB (priority) and a
// long-latency unit, with destination scoreboard, hazard and starvation stalls.
module regfile_wb_arbiter #(
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_WAIT        = 8
) (
    input logic              clock,
    input logic              reset,
    regfile_wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_OUT_C  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(32'd1);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE_C = WW'(32'd1);

    logic [31:0]     pending_r;
    logic [31:0]     pending_nxt_s;
    logic [31:0]     set_mask_s;
    logic [31:0]     clr_mask_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [WW-1:0]   wait_r;
    logic [WW-1:0]   wait_nxt_s;
    logic            waw_err_r;
    logic            waw_hit_s;
    logic            rf_we_r;
    logic [4:0]      rf_waddr_r;
    logic [XLEN-1:0] rf_wdata_r;
    logic            lu_hs_s;
    logic            iss_ready_s;
    logic            iss_inc_s;
    logic            lu_dec_s;
    logic            starve_s;
    logic            hz_s;

    // Handshakes and scoreboard next-state (issue sets, retire clears)
    always_comb begin
        lu_hs_s       = bus.lu_valid && !bus.pl_valid;
        iss_ready_s   = ((bus.iss_rd == 5'd0) || !pending_r[bus.iss_rd]) && (count_r < MAX_OUT_C);
        iss_inc_s     = bus.iss_valid && iss_ready_s && (bus.iss_rd != 5'd0);
        lu_dec_s      = lu_hs_s && (bus.lu_rd != 5'd0) && pending_r[bus.lu_rd];
        set_mask_s    = iss_inc_s ? (32'd1 << bus.iss_rd) : 32'd0;
        clr_mask_s    = (lu_hs_s && (bus.lu_rd != 5'd0)) ? (32'd1 << bus.lu_rd) : 32'd0;
        pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
        waw_hit_s     = (lu_hs_s && (bus.lu_rd != 5'd0) && !pending_r[bus.lu_rd]) ||
                        (bus.pl_valid && (bus.pl_rd != 5'd0) && pending_r[bus.pl_rd]);
    end

    // Outstanding-op counter next-state
    always_comb begin
        count_nxt_s = count_r;
        case ({iss_inc_s, lu_dec_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Starvation counter: counts cycles lu loses to pl, saturating
    always_comb begin
        wait_nxt_s = wait_r;
        if (!bus.lu_valid || lu_hs_s) begin
            wait_nxt_s = {WW{1'b0}};
        end else if (wait_r != MAX_WAIT_C) begin
            wait_nxt_s = wait_r + WAIT_ONE_C;
        end else begin
            wait_nxt_s = wait_r;
        end
    end

    // Decode hazard: state and decode inputs only, so no loop through pl/lu
    always_comb begin
        starve_s = (wait_r == MAX_WAIT_C);
        hz_s     = (bus.rs1_used && (bus.rs1 != 5'd0) && pending_r[bus.rs1]) ||
                   (bus.rs2_used && (bus.rs2 != 5'd0) && pending_r[bus.rs2]) ||
                   (bus.rd_used  && (bus.rd  != 5'd0) && pending_r[bus.rd])  ||
                   starve_s;
    end

    // Scoreboard, counters and sticky WAW flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r <= 32'd0;
            count_r   <= {CW{1'b0}};
            wait_r    <= {WW{1'b0}};
            waw_err_r <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            count_r   <= count_nxt_s;
            wait_r    <= wait_nxt_s;
            waw_err_r <= waw_err_r || waw_hit_s;
        end
    end

    // Registered write port; address/data hold when nobody is granted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= {XLEN{1'b0}};
        end else if (bus.pl_valid) begin
            rf_we_r    <= (bus.pl_rd != 5'd0);
            rf_waddr_r <= bus.pl_rd;
            rf_wdata_r <= bus.pl_data;
        end else if (bus.lu_valid) begin
            rf_we_r    <= (bus.lu_rd != 5'd0);
            rf_waddr_r <= bus.lu_rd;
            rf_wdata_r <= bus.lu_data;
        end else begin
            rf_we_r    <= 1'b0;
        end
    end

    assign bus.iss_ready = iss_ready_s;
    assign bus.lu_ready  = lu_hs_s;
    assign bus.hz_stall  = hz_s;
    assign bus.rf_we     = rf_we_r;
    assign bus.rf_waddr  = rf_waddr_r;
    assign bus.rf_wdata  = rf_wdata_r;
    assign bus.waw_err   = waw_err_r;

endmodule
